// File: rtl/axis_tx_frame_fifo.sv
// ---------------------------------------------------------------------------
// axis_tx_frame_fifo
//
// Store-and-forward AXI4-Stream frame FIFO feeding the GMII frame transmitter.
// A frame becomes visible to the read side only after its last byte has been
// written and the frame was neither marked bad nor truncated for lack of
// space. Once a frame starts on the output it streams without gaps, so the
// transmitter never sees an underrun mid-frame.
//
// Ports
//   clk                 sole clock, rising edge
//   rst_n               synchronous active-low reset
//   input_axis_*        upstream byte stream (tdata/tvalid/tready/tlast/tuser);
//                       tuser on the tlast beat marks the frame as bad
//   output_axis_*       stream to the transmitter; tuser is always 0
//   overflow            1-cycle pulse: frame dropped, buffer full
//   bad_frame           1-cycle pulse: frame dropped, tuser set on tlast
//   good_frame          1-cycle pulse: frame committed
// ---------------------------------------------------------------------------
module axis_tx_frame_fifo #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic       clk,
    input  logic       rst_n,

    input  logic [7:0] input_axis_tdata,
    input  logic       input_axis_tvalid,
    output logic       input_axis_tready,
    input  logic       input_axis_tlast,
    input  logic       input_axis_tuser,

    output logic [7:0] output_axis_tdata,
    output logic       output_axis_tvalid,
    input  logic       output_axis_tready,
    output logic       output_axis_tlast,
    output logic       output_axis_tuser,

    output logic       overflow,
    output logic       bad_frame,
    output logic       good_frame
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Pointer distance that means "every slot holds unread data".
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] PTR_ONE    = {{ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic {
        ST_WRITE,
        ST_DROP
    } wr_state_t;

    // Storage: {tlast, tdata} per slot.
    logic [8:0]            mem [0:DEPTH-1];
    logic [8:0]            mem_q;
    logic                  mem_q_valid;

    // Pointers carry one extra bit so full and empty are distinguishable.
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   wr_commit;
    logic [ADDR_WIDTH:0]   rd_ptr;

    wr_state_t             wr_state;
    wr_state_t             wr_state_next;
    logic [ADDR_WIDTH:0]   wr_ptr_next;
    logic [ADDR_WIDTH:0]   wr_commit_next;
    logic                  mem_we;
    logic                  overflow_next;
    logic                  bad_frame_next;
    logic                  good_frame_next;

    logic                  accept;
    logic                  full;
    logic                  empty;
    logic                  advance;
    logic                  rd_en;

    assign accept = input_axis_tvalid && input_axis_tready;

    // full uses the registered rd_ptr: a read in this cycle frees its slot
    // only from the next cycle on.
    assign full  = (wr_ptr - rd_ptr) == FULL_COUNT;
    assign empty = (rd_ptr == wr_commit);

    assign output_axis_tuser = 1'b0;

    // -----------------------------------------------------------------------
    // Write side: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default before any branch,
        // so no path leaves a signal unassigned and no latch is inferred.
        wr_state_next   = wr_state;
        wr_ptr_next     = wr_ptr;
        wr_commit_next  = wr_commit;
        mem_we          = 1'b0;
        overflow_next   = 1'b0;
        bad_frame_next  = 1'b0;
        good_frame_next = 1'b0;

        case (wr_state)
            ST_WRITE: begin
                if (accept) begin
                    if (full) begin
                        // No room for this beat: roll back the partial frame
                        // and swallow the remainder unless this was its end.
                        wr_ptr_next   = wr_commit;
                        overflow_next = 1'b1;
                        if (!input_axis_tlast) begin
                            wr_state_next = ST_DROP;
                        end
                    end else begin
                        mem_we      = 1'b1;
                        wr_ptr_next = wr_ptr + PTR_ONE;
                        if (input_axis_tlast) begin
                            if (input_axis_tuser) begin
                                wr_ptr_next    = wr_commit;
                                bad_frame_next = 1'b1;
                            end else begin
                                wr_commit_next  = wr_ptr + PTR_ONE;
                                good_frame_next = 1'b1;
                            end
                        end
                    end
                end
            end

            ST_DROP: begin
                if (accept && input_axis_tlast) begin
                    wr_state_next = ST_WRITE;
                end
            end

            default: wr_state_next = ST_WRITE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Read side: a two-stage pipe (RAM read register, then output register)
    // that moves as one whenever the output register can accept new data.
    // -----------------------------------------------------------------------
    assign advance = !output_axis_tvalid || output_axis_tready;
    assign rd_en   = advance && !empty;

    // NOTE: the storage array has no reset; pointers define which slots are
    // live, so clearing the array would only cost logic and block RAM mapping.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= {input_axis_tlast, input_axis_tdata};
        end
        if (rd_en) begin
            mem_q <= mem[rd_ptr[ADDR_WIDTH-1:0]];
        end
    end

    // -----------------------------------------------------------------------
    // Control and status registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: all state updates here are non-blocking so every register
        // samples the values from before this edge, independent of order.
        if (!rst_n) begin
            wr_state           <= ST_WRITE;
            wr_ptr             <= '0;
            wr_commit          <= '0;
            rd_ptr             <= '0;
            input_axis_tready  <= 1'b0;
            mem_q_valid        <= 1'b0;
            output_axis_tvalid <= 1'b0;
            output_axis_tdata  <= 8'h00;
            output_axis_tlast  <= 1'b0;
            overflow           <= 1'b0;
            bad_frame          <= 1'b0;
            good_frame         <= 1'b0;
        end else begin
            wr_state          <= wr_state_next;
            wr_ptr            <= wr_ptr_next;
            wr_commit         <= wr_commit_next;
            input_axis_tready <= 1'b1;
            overflow          <= overflow_next;
            bad_frame         <= bad_frame_next;
            good_frame        <= good_frame_next;

            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end

            if (advance) begin
                mem_q_valid        <= !empty;
                output_axis_tvalid <= mem_q_valid;
                // Keep the last byte on the bus when nothing new arrives.
                if (mem_q_valid) begin
                    output_axis_tdata <= mem_q[7:0];
                    output_axis_tlast <= mem_q[8];
                end
            end
        end
    end

endmodule

// File: tb/tb_axis_tx_frame_fifo.sv
// ---------------------------------------------------------------------------
// tb_axis_tx_frame_fifo
//
// Two instances share one stimulus stream: dut_big (ADDR_WIDTH=12) and
// dut_small (ADDR_WIDTH=6). sel routes input valid to one of them and picks
// which one's outputs the monitor watches. Expected output beats are queued
// as frames are driven and popped as the selected instance hands them over.
// ---------------------------------------------------------------------------
module tb_axis_tx_frame_fifo;

    logic       clk;
    logic       rst_n;
    logic       sel;

    logic [7:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic       in_user;
    logic       out_ready;

    logic       b_in_ready, b_out_valid, b_out_last, b_out_user;
    logic       b_ovf, b_bad, b_good;
    logic [7:0] b_out_data;
    logic       s_in_ready, s_out_valid, s_out_last, s_out_user;
    logic       s_ovf, s_bad, s_good;
    logic [7:0] s_out_data;

    logic       b_in_valid, s_in_valid;
    logic       m_in_ready, m_valid, m_last, m_user, m_ovf, m_bad, m_good;
    logic [7:0] m_data;

    assign b_in_valid = in_valid && !sel;
    assign s_in_valid = in_valid && sel;

    assign m_in_ready = sel ? s_in_ready  : b_in_ready;
    assign m_valid    = sel ? s_out_valid : b_out_valid;
    assign m_data     = sel ? s_out_data  : b_out_data;
    assign m_last     = sel ? s_out_last  : b_out_last;
    assign m_user     = sel ? s_out_user  : b_out_user;
    assign m_ovf      = sel ? s_ovf       : b_ovf;
    assign m_bad      = sel ? s_bad       : b_bad;
    assign m_good     = sel ? s_good      : b_good;

    axis_tx_frame_fifo #(.ADDR_WIDTH(12)) dut_big (
        .clk                (clk),
        .rst_n              (rst_n),
        .input_axis_tdata   (in_data),
        .input_axis_tvalid  (b_in_valid),
        .input_axis_tready  (b_in_ready),
        .input_axis_tlast   (in_last),
        .input_axis_tuser   (in_user),
        .output_axis_tdata  (b_out_data),
        .output_axis_tvalid (b_out_valid),
        .output_axis_tready (out_ready),
        .output_axis_tlast  (b_out_last),
        .output_axis_tuser  (b_out_user),
        .overflow           (b_ovf),
        .bad_frame          (b_bad),
        .good_frame         (b_good)
    );

    axis_tx_frame_fifo #(.ADDR_WIDTH(6)) dut_small (
        .clk                (clk),
        .rst_n              (rst_n),
        .input_axis_tdata   (in_data),
        .input_axis_tvalid  (s_in_valid),
        .input_axis_tready  (s_in_ready),
        .input_axis_tlast   (in_last),
        .input_axis_tuser   (in_user),
        .output_axis_tdata  (s_out_data),
        .output_axis_tvalid (s_out_valid),
        .output_axis_tready (out_ready),
        .output_axis_tlast  (s_out_last),
        .output_axis_tuser  (s_out_user),
        .overflow           (s_ovf),
        .bad_frame          (s_bad),
        .good_frame         (s_good)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fails  = 0;
    logic [8:0] q[$];
    int         good_cnt, bad_cnt, ovf_cnt;
    int         ovf_beat;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        good_cnt = 0;
        bad_cnt  = 0;
        ovf_cnt  = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        q.delete();
        clear_counts();
    endtask

    // Drive one frame, one beat per cycle. Records in ovf_beat the 1-based
    // index of the beat whose acceptance produced an overflow pulse.
    task automatic send_frame(input int len, input int first, input bit user,
                              input bit expect_out);
        check("in_ready", 32'(m_in_ready), 32'd1);
        ovf_beat = 0;
        for (int i = 0; i < len; i++) begin
            in_data  = 8'(first + i);
            in_valid = 1'b1;
            in_last  = (i == len - 1);
            in_user  = user && (i == len - 1);
            if (expect_out) q.push_back({in_last, in_data});
            tick();
            if (m_ovf && ovf_beat == 0) ovf_beat = i + 1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_user  = 1'b0;
    endtask

    task automatic drain(input int budget);
        for (int n = 0; n < budget && q.size() != 0; n++) tick();
        check("drain_done", 32'(q.size()), 32'd0);
        repeat (4) tick();
    endtask

    // Output monitor: runs on the falling edge, where handshakes for the
    // coming rising edge are already settled.
    logic [8:0] prev_beat;
    logic       prev_stall;
    logic       in_frame;
    logic [8:0] exp_beat;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
            in_frame   = 1'b0;
        end else begin
            if (m_good) good_cnt++;
            if (m_bad)  bad_cnt++;
            if (m_ovf)  ovf_cnt++;
            if (prev_stall)
                check("stall_hold", 32'({m_valid, m_last, m_data}), 32'({1'b1, prev_beat}));
            else if (in_frame)
                check("frame_gap", 32'(m_valid), 32'd1);
            if (m_valid) check("out_tuser", 32'(m_user), 32'd0);
            if (m_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("extra_beat", 32'({m_last, m_data}), 32'hFFFF_FFFF);
                end else begin
                    exp_beat = q.pop_front();
                    check("beat", 32'({m_last, m_data}), 32'(exp_beat));
                end
                in_frame   = !m_last;
                prev_stall = 1'b0;
            end else begin
                prev_stall = m_valid;
                prev_beat  = {m_last, m_data};
            end
        end
    end

    initial begin
        repeat (50000) @(posedge clk);
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        sel       = 1'b0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_user   = 1'b0;
        out_ready = 1'b0;
        clear_counts();

        // Reset state of both instances.
        repeat (3) tick();
        check("rst_in_ready_big",   32'(b_in_ready),  32'd0);
        check("rst_in_ready_small", 32'(s_in_ready),  32'd0);
        check("rst_tvalid_big",     32'(b_out_valid), 32'd0);
        check("rst_tvalid_small",   32'(s_out_valid), 32'd0);
        check("rst_tdata",          32'(b_out_data),  32'd0);
        check("rst_tlast",          32'(b_out_last),  32'd0);
        check("rst_tuser",          32'(b_out_user),  32'd0);
        check("rst_status",         32'({b_ovf, b_bad, b_good}), 32'd0);
        rst_n = 1'b1;
        check("in_ready_before_edge", 32'(m_in_ready), 32'd0);
        tick();
        check("in_ready_after_edge",  32'(m_in_ready), 32'd1);

        // Single 64-byte frame, tvalid two edges after the tlast edge.
        out_ready = 1'b1;
        clear_counts();
        send_frame(64, 8'h00, 1'b0, 1'b1);
        check("t1_good_pulse", 32'(m_good),  32'd1);
        check("t1_valid_n0",   32'(m_valid), 32'd0);
        tick();
        check("t1_good_clear", 32'(m_good),  32'd0);
        check("t1_valid_n1",   32'(m_valid), 32'd0);
        tick();
        check("t1_valid_n2",   32'(m_valid), 32'd1);
        drain(200);
        check("t1_good_count", 32'(good_cnt), 32'd1);

        // Bad frame is discarded, the following good frame passes.
        do_reset();
        out_ready = 1'b1;
        send_frame(30, 8'h80, 1'b1, 1'b0);
        check("t2_bad_pulse",  32'(m_bad),  32'd1);
        check("t2_no_good",    32'(m_good), 32'd0);
        check("t2_wr_ptr_rb",  32'(dut_big.wr_ptr), 32'd0);
        send_frame(60, 8'h00, 1'b0, 1'b1);
        check("t2_good_pulse", 32'(m_good), 32'd1);
        drain(200);
        check("t2_wr_ptr",     32'(dut_big.wr_ptr),    32'd60);
        check("t2_wr_commit",  32'(dut_big.wr_commit), 32'd60);
        check("t2_counts",     32'({8'(bad_cnt), 8'(good_cnt), 8'(ovf_cnt)}), 32'h00_01_01_00);

        // Small buffer: 80-byte frame overflows on beat 65, next frame intact.
        sel = 1'b1;
        out_ready = 1'b0;
        do_reset();
        send_frame(80, 8'h00, 1'b0, 1'b0);
        check("t3_ovf_beat",  32'(ovf_beat), 32'd65);
        check("t3_ovf_count", 32'(ovf_cnt),  32'd1);
        check("t3_no_good",   32'(good_cnt), 32'd0);
        send_frame(10, 8'hA0, 1'b0, 1'b1);
        check("t3_good_pulse", 32'(m_good), 32'd1);
        out_ready = 1'b1;
        drain(100);
        check("t3_final_counts", 32'({8'(ovf_cnt), 8'(good_cnt)}), 32'h0000_0101);

        // Small buffer: exact 64-byte frame fills it; next frame overflows.
        out_ready = 1'b0;
        do_reset();
        send_frame(64, 8'h40, 1'b0, 1'b1);
        check("t4_good_pulse", 32'(m_good), 32'd1);
        check("t4_no_ovf",     32'(m_ovf),  32'd0);
        check("t4_full",       32'(dut_small.full), 32'd1);
        send_frame(5, 8'hF0, 1'b0, 1'b0);
        check("t4_ovf_beat",   32'(ovf_beat), 32'd1);
        check("t4_counts",     32'({8'(ovf_cnt), 8'(good_cnt)}), 32'h0000_0101);
        out_ready = 1'b1;
        drain(200);

        // Transmitter-style back-pressure across two back-to-back frames.
        sel = 1'b0;
        out_ready = 1'b0;
        do_reset();
        send_frame(40, 8'h20, 1'b0, 1'b1);
        send_frame(20, 8'h60, 1'b0, 1'b1);
        for (int n = 0; n < 20 && !m_valid; n++) tick();
        check("t5_valid_rise", 32'(m_valid), 32'd1);
        repeat (8) tick();
        for (int n = 0; n < 400 && q.size() != 0; n++) begin
            out_ready = !out_ready;
            tick();
        end
        check("t5_drained", 32'(q.size()), 32'd0);
        out_ready = 1'b1;
        repeat (4) tick();
        check("t5_good_count", 32'(good_cnt), 32'd2);

        // Reset in the middle of an output frame.
        do_reset();
        out_ready = 1'b1;
        send_frame(100, 8'h10, 1'b0, 1'b1);
        for (int n = 0; n < 100 && q.size() > 60; n++) tick();
        check("t6_mid_frame", 32'(m_valid), 32'd1);
        rst_n = 1'b0;
        tick();
        check("t6_rst_valid", 32'(m_valid),    32'd0);
        check("t6_rst_ready", 32'(m_in_ready), 32'd0);
        q.delete();
        rst_n = 1'b1;
        tick();
        check("t6_ready_back", 32'(m_in_ready), 32'd1);
        check("t6_no_stale",   32'(m_valid),    32'd0);
        clear_counts();
        send_frame(20, 8'h33, 1'b0, 1'b1);
        drain(100);
        check("t6_good_count", 32'(good_cnt), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/axis_tx_frame_fifo.md
# axis_tx_frame_fifo

Store-and-forward AXI4-Stream frame FIFO that sits directly upstream of the GMII frame transmitter. It buffers each outgoing frame in full and releases it only once its last byte has been accepted. Once a frame has started, output tvalid therefore never drops mid-frame, so the transmitter never aborts a frame on a data underrun. Errored and oversize frames are discarded here and never reach the transmitter.

## Interface
- ADDR_WIDTH, 12: buffer depth is 2^ADDR_WIDTH bytes (4096); the largest accepted frame is exactly 2^ADDR_WIDTH bytes.
- clk  in  1  sole clock; all logic on its rising edge.
- rst_n  in  1  reset: synchronous, active-low.
- input_axis_tdata  in  8  frame byte.
- input_axis_tvalid  in  1  byte valid.
- input_axis_tready  out  1  byte accepted.
- input_axis_tlast  in  1  last byte of frame.
- input_axis_tuser  in  1  bad-frame marker, sampled on the tlast beat.
- output_axis_tdata  out  8  to transmitter.
- output_axis_tvalid  out  1  to transmitter.
- output_axis_tready  in  1  from transmitter.
- output_axis_tlast  out  1  to transmitter.
- output_axis_tuser  out  1  tied 0; bad frames never leave this block.
- overflow  out  1  one-cycle pulse: a frame was dropped for lack of space.
- bad_frame  out  1  one-cycle pulse: a frame was dropped because tuser was set.
- good_frame  out  1  one-cycle pulse: a frame was committed.

## Operation
- Storage: 2^ADDR_WIDTH x 9-bit memory holding {tlast, tdata}, with a synchronous read port.
- Pointers are ADDR_WIDTH+1 bits and wrap naturally; the memory is addressed by the low ADDR_WIDTH bits.
  - wr_ptr: next write location.
  - wr_commit: end of the last committed frame.
  - rd_ptr: next read location.
- full = (wr_ptr − rd_ptr) == 2^ADDR_WIDTH. empty = (rd_ptr == wr_commit).
- input_axis_tready is 1 at all times outside reset; the block never back-pressures.
- Write side states: WRITE and DROP.
- WRITE, accepted beat, not full:
  - store the beat; wr_ptr+1.
  - If tlast and !tuser: wr_commit ← wr_ptr+1; good_frame pulses.
  - If tlast and tuser: wr_ptr ← wr_commit; bad_frame pulses.
- WRITE, accepted beat, full (tlast or not):
  - nothing is stored; wr_ptr ← wr_commit; overflow pulses.
  - If the beat is not tlast, go to DROP. If it is tlast, stay in WRITE.
- DROP: discard beats until tlast, then return to WRITE. DROP does not pulse any status output.
- A tlast beat that lands in the final free slot is stored and committed normally. After it the buffer is full; this is not an overflow.
- Read side, one output register:
  - Load when !empty and (!output_axis_tvalid or output_axis_tready).
  - On load, the memory is read at rd_ptr, rd_ptr+1, and output_axis_tvalid is set on the next cycle.
  - output_axis_tvalid clears when a handshake completes and no load is pending.
  - While output_axis_tvalid=1 and output_axis_tready=0, output tdata/tlast hold stable.
- Reads and writes in the same cycle are independent. full uses the registered rd_ptr, so a read in the same cycle does not free space until the next cycle.
- Because the read side only reads committed data, frames leave back-to-back in commit order. Dropped bytes are never read.

## Timing
- Reset (rst_n=0 at a rising edge) sets:
  - wr_ptr = wr_commit = rd_ptr = 0, write state WRITE;
  - input_axis_tready = 0, output_axis_tvalid = 0, output_axis_tdata = 0, output_axis_tlast = 0, output_axis_tuser = 0;
  - overflow = bad_frame = good_frame = 0.
- input_axis_tready rises on the first edge after rst_n returns high.
- Reset mid-frame discards all contents, both partial and committed. Output tvalid drops immediately, including in the middle of an output frame.
- Commit latency: a tlast beat accepted at edge N updates wr_commit at N; the memory read issues at N+1; output_axis_tvalid=1 from edge N+2.
- good_frame, bad_frame and overflow are registered and high for exactly the one cycle after the deciding beat.
- Throughput: 1 byte/cycle in each direction, sustained while output_axis_tready=1. Zero bubbles between consecutive committed frames.
- No combinational path from output_axis_tready to input_axis_tready, or from input to output.

## Test plan
- Single 64-byte frame (bytes 0x00..0x3F, tuser=0), output_axis_tready=1 -> good_frame pulses once. tvalid rises 2 cycles after the tlast beat. 64 consecutive output beats 0x00..0x3F, tlast only on 0x3F.
- Frame with tuser=1 on tlast, then a 60-byte good frame -> bad_frame pulses. Output contains only the 60-byte frame; wr_ptr equals 60 afterwards.
- ADDR_WIDTH=6, output_axis_tready=0, 80-byte frame:
  - overflow pulses on beat 65 and the frame is discarded;
  - a following 10-byte frame commits and is output intact once tready=1;
  - no output of the dropped frame.
- ADDR_WIDTH=6, exactly 64-byte frame with tready=0 -> committed, full=1, no overflow. The next frame's first beat triggers overflow.
- Transmitter-style back-pressure: output_axis_tready=0 for the first 8 cycles after tvalid, then toggling 1/0 -> tdata and tlast stable while stalled; byte order preserved; tvalid never drops before tlast.
- rst_n=0 for one cycle mid-output-frame -> next cycle tvalid=0 and tready=0. After release, a new 20-byte frame passes intact and no stale data appears.
